// File: rtl/loader_pkg.sv
// Shared types for the CPU memory loader: state encoding and stream data width.
package loader_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit sum of the loaded image and compare against the trailing check byte.
// Instantiated by mem_loader only when MEM_LOADER_CHECKSUM_EN is defined.
module loader_csum
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              chk_en,
    input  logic [DATA_W-1:0] chk_data,
    output logic              csum_err
);

    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sum      <= '0;
            csum_err <= 1'b0;
        end else begin
            if (acc_en) begin
                sum <= sum + acc_data;
            end
            if (chk_en) begin
                csum_err <= (chk_data != sum);
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Streams a boot image into CPU byte memory and holds the CPU in reset until it is in.
// Optional trailing checksum byte: define MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              csum_err
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  count_nx;
    logic [LEN_W-1:0]  len_cl;
    logic [ADDR_W-1:0] addr;
    logic              start_ok;
    logic              hs_load;

    always_comb begin
        in_ready = (state == LOAD);
`ifdef MEM_LOADER_CHECKSUM_EN
        in_ready = in_ready || (state == CHECK);
`endif
    end

    assign busy     = (state inside {LOAD, CHECK, RELEASE});
    assign cpu_rst  = (state != DONE);
    assign done     = (state == DONE);
    assign start_ok = start_i && (state == IDLE || state == DONE);
    assign hs_load  = in_valid && in_ready && (state == LOAD);
    assign count_nx = count + LEN_W'(1);
    assign len_cl   = (len_i > DEPTH_L) ? DEPTH_L : len_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        len   <= len_cl;
                        count <= '0;
                        addr  <= '0;
                        state <= (len_cl == '0) ? RELEASE : LOAD;
                    end
                end
                LOAD: begin
                    if (hs_load) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + ADDR_W'(1);
                        count     <= count_nx;
                        // Full-depth loads wrap addr to 0 here, but the FSM leaves LOAD first.
                        if (count_nx == len) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= RELEASE;
`endif
                        end
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (in_valid) begin
                        state <= RELEASE;
                    end
                end
`endif
                RELEASE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    loader_csum u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .acc_en   (hs_load),
        .acc_data (in_data),
        .chk_en   ((state == CHECK) && in_valid),
        .chk_data (in_data),
        .csum_err (csum_err)
    );
`else
    assign csum_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader; checksum scenarios run when MEM_LOADER_CHECKSUM_EN is defined.
module tb_mem_loader;
    import loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic [8:0] len_i = '0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, mem_we, cpu_rst, busy, done, csum_err;
    logic [7:0] mem_addr, mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;

    logic [7:0]  wa[$];
    logic [7:0]  wd[$];
    int unsigned wc[$];

    mem_loader #(.ADDR_W(8), .LEN_W(9)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .csum_err(csum_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wc.delete();
    endtask

    task automatic start_load(input logic [8:0] l);
        start_i = 1'b1;
        len_i   = l;
        tick();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr got %h exp 00", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata got %h exp 00", mem_wdata); end
        n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst got %b exp 1", cpu_rst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b exp 0", done); end
        n_checks++; if (csum_err !== 1'b0) begin n_fail++; $display("FAIL rst_csum_err got %b exp 0", csum_err); end
        rst = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL idle_hold got busy=%b cpu_rst=%b exp 0/1", busy, cpu_rst); end
    endtask

    task automatic test_basic();
        clear_log();
        start_load(9'd3);
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_load_entry got rdy=%b busy=%b exp 1/1", in_ready, busy); end
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        n_checks++; if (in_ready !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_release got rdy=%b cpu_rst=%b done=%b busy=%b exp 0/1/0/1", in_ready, cpu_rst, done, busy);
        end
        tick();
        n_checks++; if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got done=%b cpu_rst=%b busy=%b exp 1/0/0", done, cpu_rst, busy);
        end
        n_checks++; if (csum_err !== 1'b0) begin n_fail++; $display("FAIL basic_csum got %b exp 0", csum_err); end
        n_checks++;
        if (wa.size() != 3) begin
            n_fail++; $display("FAIL basic_write_count got %0d exp 3", wa.size());
        end else if (wa[0] !== 8'h00 || wd[0] !== 8'h01 || wa[1] !== 8'h01 || wd[1] !== 8'h02 ||
                     wa[2] !== 8'h02 || wd[2] !== 8'h03) begin
            n_fail++; $display("FAIL basic_writes got (%h,%h)(%h,%h)(%h,%h) exp (00,01)(01,02)(02,03)",
                               wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
        end
        n_checks++;
        if (wc.size() == 3 && (wc[1] != wc[0] + 1 || wc[2] != wc[1] + 1)) begin
            n_fail++; $display("FAIL basic_consecutive got cycles %0d,%0d,%0d exp consecutive", wc[0], wc[1], wc[2]);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] img [3];
        img = '{8'h01, 8'h02, 8'h03};
        clear_log();
        start_load(9'd3);
        n_checks++; if (done !== 1'b0 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL reload got done=%b cpu_rst=%b exp 0/1", done, cpu_rst); end
        for (int i = 0; i < 3; i++) send_byte(img[i], (i < 2) ? 2 : 0);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'h06, 0);
`endif
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL gaps_release got rdy=%b busy=%b exp 0/1", in_ready, busy); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL gaps_done got %b exp 1", done); end
        n_checks++;
        if (wa.size() != 3) begin
            n_fail++; $display("FAIL gaps_write_count got %0d exp 3", wa.size());
        end else if (wa[0] !== 8'h00 || wd[0] !== 8'h01 || wa[1] !== 8'h01 || wd[1] !== 8'h02 ||
                     wa[2] !== 8'h02 || wd[2] !== 8'h03) begin
            n_fail++; $display("FAIL gaps_writes got (%h,%h)(%h,%h)(%h,%h) exp (00,01)(01,02)(02,03)",
                               wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
        end
    endtask

    task automatic test_len_zero();
        clear_log();
        start_load(9'd0);
        n_checks++; if (busy !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL len0_release got busy=%b cpu_rst=%b done=%b rdy=%b exp 1/1/0/0", busy, cpu_rst, done, in_ready);
        end
        tick();
        n_checks++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL len0_done got done=%b cpu_rst=%b exp 1/0", done, cpu_rst); end
        n_checks++; if (wa.size() != 0) begin n_fail++; $display("FAIL len0_writes got %0d exp 0", wa.size()); end
    endtask

    task automatic test_full();
        logic [7:0] sum;
        int bad;
        sum = '0;
        bad = 0;
        clear_log();
        start_load(9'd300);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i) ^ 8'h5A;
            sum = sum + b;
            send_byte(b, 0);
        end
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(sum, 0);
`endif
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL full_release got rdy=%b busy=%b exp 0/1 (sum %h)", in_ready, busy, sum); end
        tick();
        n_checks++; if (done !== 1'b1 || csum_err !== 1'b0) begin n_fail++; $display("FAIL full_done got done=%b csum_err=%b exp 1/0", done, csum_err); end
        n_checks++;
        if (wa.size() != 256) begin
            n_fail++; $display("FAIL full_write_count got %0d exp 256", wa.size());
        end else begin
            for (int i = 0; i < 256; i++)
                if (wa[i] !== 8'(i) || wd[i] !== (8'(i) ^ 8'h5A)) bad++;
            if (bad != 0) begin n_fail++; $display("FAIL full_writes got %0d bad entries exp 0", bad); end
        end
    endtask

    task automatic test_reset_midload();
        clear_log();
        start_load(9'd5);
        send_byte(8'hA1, 0);
        send_byte(8'hA2, 0);
        rst = 1'b1;
        tick();
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            n_fail++; $display("FAIL abort_mem got we=%b addr=%h data=%h exp 0/00/00", mem_we, mem_addr, mem_wdata);
        end
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cpu_rst !== 1'b1 || csum_err !== 1'b0) begin
            n_fail++; $display("FAIL abort_ctrl got rdy=%b busy=%b done=%b cpu_rst=%b err=%b exp 0/0/0/1/0",
                               in_ready, busy, done, cpu_rst, csum_err);
        end
        rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got rdy=%b busy=%b exp 0/0", in_ready, busy); end
        n_checks++;
        if (wa.size() != 2) begin
            n_fail++; $display("FAIL abort_partial got %0d writes exp 2", wa.size());
        end else if (wa[0] !== 8'h00 || wd[0] !== 8'hA1 || wa[1] !== 8'h01 || wd[1] !== 8'hA2) begin
            n_fail++; $display("FAIL abort_partial got (%h,%h)(%h,%h) exp (00,a1)(01,a2)", wa[0], wd[0], wa[1], wd[1]);
        end
    endtask

    task automatic test_start_ignored();
        clear_log();
        start_load(9'd3);
        send_byte(8'h11, 0);
        start_i = 1'b1;
        len_i   = 9'd9;
        send_byte(8'h22, 0);
        start_i = 1'b0;
        len_i   = '0;
        send_byte(8'h33, 0);
`ifdef MEM_LOADER_CHECKSUM_EN
        send_byte(8'h66, 0);
`endif
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL ignore_release got rdy=%b busy=%b exp 0/1", in_ready, busy); end
        tick();
        n_checks++; if (done !== 1'b1 || csum_err !== 1'b0) begin n_fail++; $display("FAIL ignore_done got done=%b err=%b exp 1/0", done, csum_err); end
        n_checks++;
        if (wa.size() != 3) begin
            n_fail++; $display("FAIL ignore_write_count got %0d exp 3", wa.size());
        end else if (wa[2] !== 8'h02 || wd[2] !== 8'h33) begin
            n_fail++; $display("FAIL ignore_last got (%h,%h) exp (02,33)", wa[2], wd[2]);
        end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        start_load(9'd3);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL csum_check_ready got %b exp 1", in_ready); end
        send_byte(8'h07, 0);
        tick();
        n_checks++; if (done !== 1'b1 || csum_err !== 1'b1 || cpu_rst !== 1'b0) begin
            n_fail++; $display("FAIL csum_bad got done=%b err=%b cpu_rst=%b exp 1/1/0", done, csum_err, cpu_rst);
        end
        n_checks++; if (wa.size() != 3) begin n_fail++; $display("FAIL csum_no_write got %0d writes exp 3", wa.size()); end
        clear_log();
        start_load(9'd3);
        n_checks++; if (csum_err !== 1'b0) begin n_fail++; $display("FAIL csum_clear got %b exp 0", csum_err); end
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h06, 0);
        tick();
        n_checks++; if (done !== 1'b1 || csum_err !== 1'b0) begin n_fail++; $display("FAIL csum_good got done=%b err=%b exp 1/0", done, csum_err); end
        n_checks++; if (wa.size() != 3) begin n_fail++; $display("FAIL csum_good_writes got %0d exp 3", wa.size()); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_full();
        test_reset_midload();
        test_start_ignored();
`ifdef MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
